// File: rtl/timer_sched.sv
// timer_sched: queues countdown requests from several game objects
// and runs them one at a time on the shared frame countdown.
module timer_sched #(
   parameter int NUM_REQ    = 4,
   parameter int FIFO_DEPTH = 4,
   parameter int TIME_W     = 11,
   localparam int ID_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
   localparam int PTR_W = $clog2(FIFO_DEPTH),
   localparam int CNT_W = PTR_W + 1
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [NUM_REQ-1:0]        req_valid,
   input  logic [NUM_REQ*TIME_W-1:0] req_time,
   output logic [NUM_REQ-1:0]        req_ready,
   input  logic                      cancel_all,
   output logic                      request_start,
   output logic [TIME_W-1:0]         requested_time,
   input  logic                      timer_done,
   output logic                      expired_valid,
   output logic [ID_W-1:0]           expired_id,
   output logic                      busy,
   output logic [CNT_W-1:0]          fifo_count
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LAUNCH = 2'd1,
      WAIT   = 2'd2
   } state_t;

   state_t state;
   state_t state_nxt;

   logic [ID_W-1:0]   fifo_id   [FIFO_DEPTH];
   logic [TIME_W-1:0] fifo_time [FIFO_DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;

   logic [NUM_REQ-1:0] grant;
   logic [ID_W-1:0]    win_id;
   logic [TIME_W-1:0]  win_time;
   logic               found;
   logic               full;
   logic               push_ok;
   logic               push;
   logic               pop;
   logic               exp_nxt;
   logic [ID_W-1:0]    current_id;

   assign full    = (fifo_count == CNT_W'(FIFO_DEPTH));
   assign push_ok = !reset && !full && !cancel_all;

   // Fixed-priority pick: lowest requesting index wins.
   always_comb begin
      grant    = '0;
      win_id   = '0;
      win_time = '0;
      found    = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (req_valid[i] && !found) begin
            found    = 1'b1;
            grant[i] = 1'b1;
            win_id   = ID_W'(i);
            win_time = req_time[i*TIME_W +: TIME_W];
         end
      end
   end

   assign req_ready = push_ok ? grant : '0;
   assign push      = push_ok && found;

   // Queue storage; only the slot under wr_ptr changes on a push.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_id[wr_ptr]   <= win_id;
         fifo_time[wr_ptr] <= win_time;
      end
   end

   // Circular pointers and occupancy; cancel flushes the queue.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
      end else if (cancel_all) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         if (push && !pop) begin
            fifo_count <= fifo_count + CNT_W'(1);
         end else if (pop && !push) begin
            fifo_count <= fifo_count - CNT_W'(1);
         end
      end
   end

   // Scheduler state, launch operands and the expiry report.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state          <= IDLE;
         requested_time <= '0;
         current_id     <= '0;
         expired_valid  <= 1'b0;
         expired_id     <= '0;
      end else begin
         state         <= state_nxt;
         expired_valid <= exp_nxt;
         if (pop) begin
            requested_time <= fifo_time[rd_ptr];
            current_id     <= fifo_id[rd_ptr];
         end
         if (exp_nxt) begin
            expired_id <= current_id;
         end
      end
   end

   // Next state; the expiry cycle holds off the next pop by one.
   always_comb begin
      state_nxt = state;
      pop       = 1'b0;
      exp_nxt   = 1'b0;
      if (cancel_all) begin
         state_nxt = IDLE;
      end else begin
         unique case (state)
            IDLE: begin
               if (fifo_count != '0 && !expired_valid) begin
                  pop       = 1'b1;
                  state_nxt = LAUNCH;
               end
            end
            LAUNCH: begin
               state_nxt = WAIT;
            end
            WAIT: begin
               if (timer_done) begin
                  exp_nxt   = 1'b1;
                  state_nxt = IDLE;
               end
            end
            default: begin
               state_nxt = IDLE;
            end
         endcase
      end
   end

   assign request_start = (state == LAUNCH);
   assign busy          = (state == LAUNCH) || (state == WAIT);

endmodule
